// File: rtl/pad_mux_pkg.sv
// Shared types and address-field constants for the pad_mux pin multiplexer.
package pad_mux_pkg;

   localparam int RegionW = 2;
   localparam int IndexW  = 8;
   localparam int AddrW   = RegionW + IndexW;
   localparam int DataW   = 8;
   localparam int SelSpan = 1 << IndexW;

   typedef enum logic [RegionW-1:0] {
      RegionOutSel = 2'd0,
      RegionInSel  = 2'd1,
      RegionAttr   = 2'd2,
      RegionCtrl   = 2'd3
   } region_e;

   typedef struct packed {
      logic filter_en;
      logic drive_strength;
   } pad_attr_t;

endpackage

// File: rtl/pad_mux_filter.sv
// Per-pad 2-flop synchroniser with optional glitch filter.
// The filter is only built when PAD_MUX_FILTER_EN is defined.
module pad_mux_filter #(
   parameter int FilterCycles = 4
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic pad_i,
   input  logic filter_en_i,
   output logic filt_o
);

   logic sync1_q, sync2_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= pad_i;
         sync2_q <= sync1_q;
      end
   end

`ifdef PAD_MUX_FILTER_EN
   localparam int CntW = $clog2(FilterCycles + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(FilterCycles - 1);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            stable_q, stable_d;

   // Count consecutive cycles the synchronised value disagrees with the accepted one.
   always_comb begin
      cnt_d    = '0;
      stable_d = stable_q;
      if (sync2_q != stable_q) begin
         if (cnt_q == CntMax) begin
            cnt_d    = cnt_q;
            stable_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q    <= '0;
         stable_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
      end
   end

   assign filt_o = filter_en_i ? stable_q : sync2_q;
`else
   logic unused_filter_en;
   assign unused_filter_en = filter_en_i;
   assign filt_o           = sync2_q;
`endif

endmodule

// File: rtl/pad_mux.sv
// Run-time programmable pin multiplexer between peripheral cio_* signals and the padring.
// Optional glitch filtering on pad inputs is enabled with PAD_MUX_FILTER_EN.
module pad_mux
   import pad_mux_pkg::*;
#(
   parameter int NPads        = 59,
   parameter int NPeriphOut   = 64,
   parameter int NPeriphIn    = 48,
   parameter int FilterCycles = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   reg_req_i,
   input  logic                   reg_we_i,
   input  logic [AddrW-1:0]       reg_addr_i,
   input  logic [DataW-1:0]       reg_wdata_i,
   output logic                   reg_rvalid_o,
   output logic [DataW-1:0]       reg_rdata_o,
   output logic                   reg_err_o,
   input  logic [NPeriphOut-1:0]  periph_out_i,
   input  logic [NPeriphOut-1:0]  periph_oe_i,
   output logic [NPeriphIn-1:0]   periph_in_o,
   input  logic [NPads-1:0]       pad_in_i,
   output logic [NPads-1:0]       pad_out_o,
   output logic [NPads-1:0]       pad_oe_o,
   output logic [2*NPads-1:0]     pad_attr_o,
   output logic                   locked_o
);

   logic [DataW-1:0] outsel_q [NPads];
   logic [DataW-1:0] insel_q  [NPeriphIn];
   pad_attr_t        attr_q   [NPads];
   logic             lock_q;
   logic             rvalid_q, err_q;
   logic [DataW-1:0] rdata_q, rdata_d;
   logic             idx_valid, access_err, wr_en;
   logic [NPads-1:0] pad_filt;

   region_e         region;
   logic [IndexW-1:0] idx;
   assign region = region_e'(reg_addr_i[AddrW-1:IndexW]);
   assign idx    = reg_addr_i[IndexW-1:0];

   always_comb begin
      idx_valid = 1'b0;
      rdata_d   = '0;
      case (region)
         RegionOutSel: for (int p = 0; p < NPads; p++)
            if (int'(idx) == p) begin idx_valid = 1'b1; rdata_d = outsel_q[p]; end
         RegionInSel: for (int i = 0; i < NPeriphIn; i++)
            if (int'(idx) == i) begin idx_valid = 1'b1; rdata_d = insel_q[i]; end
         RegionAttr: for (int p = 0; p < NPads; p++)
            if (int'(idx) == p) begin idx_valid = 1'b1; rdata_d = DataW'(attr_q[p]); end
         default: if (idx == '0) begin idx_valid = 1'b1; rdata_d = DataW'(lock_q); end
      endcase
   end

   assign access_err = !idx_valid || (reg_we_i && lock_q);
   assign wr_en      = reg_req_i && reg_we_i && !access_err;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
         lock_q   <= 1'b0;
      end else begin
         rvalid_q <= reg_req_i;
         err_q    <= reg_req_i && access_err;
         rdata_q  <= (reg_req_i && !reg_we_i && !access_err) ? rdata_d : '0;
         if (wr_en && region == RegionCtrl && reg_wdata_i[0]) lock_q <= 1'b1;
      end
   end

   assign reg_rvalid_o = rvalid_q;
   assign reg_err_o    = err_q;
   assign reg_rdata_o  = rdata_q;
   assign locked_o     = lock_q;

   // Select value 0 and anything past the last source land on a zero bit of these vectors.
   logic [SelSpan-1:0] out_ext, oe_ext, filt_ext;
   assign out_ext  = SelSpan'({periph_out_i, 1'b0});
   assign oe_ext   = SelSpan'({periph_oe_i, 1'b0});
   assign filt_ext = SelSpan'({pad_filt, 1'b0});

   for (genvar gi = 0; gi < NPads; gi++) begin : g_pad
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            outsel_q[gi] <= '0;
            attr_q[gi]   <= '0;
         end else if (wr_en && int'(idx) == gi) begin
            if (region == RegionOutSel) outsel_q[gi] <= reg_wdata_i;
            if (region == RegionAttr)   attr_q[gi]   <= pad_attr_t'(reg_wdata_i[1:0]);
         end
      end

      assign pad_out_o[gi]          = out_ext[outsel_q[gi]];
      assign pad_oe_o[gi]           = oe_ext[outsel_q[gi]];
      assign pad_attr_o[2*gi +: 2]  = attr_q[gi];

      pad_mux_filter #(
         .FilterCycles(FilterCycles)
      ) u_filter (
         .clk_i      (clk_i),
         .rst_ni     (rst_ni),
         .pad_i      (pad_in_i[gi]),
         .filter_en_i(attr_q[gi].filter_en),
         .filt_o     (pad_filt[gi])
      );
   end

   for (genvar gi = 0; gi < NPeriphIn; gi++) begin : g_in
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            insel_q[gi] <= '0;
         end else if (wr_en && region == RegionInSel && int'(idx) == gi) begin
            insel_q[gi] <= reg_wdata_i;
         end
      end

      assign periph_in_o[gi] = filt_ext[insel_q[gi]];
   end

endmodule

// File: tb/tb_pad_mux.sv
// Directed self-checking bench for pad_mux (default parameters).
module tb_pad_mux;

   localparam int NPads = 59, NPeriphOut = 64, NPeriphIn = 48, FilterCycles = 4;
`ifdef PAD_MUX_FILTER_EN
   localparam bit FiltOn = 1'b1;
`else
   localparam bit FiltOn = 1'b0;
`endif

   logic                  clk_i = 1'b0;
   logic                  rst_ni;
   logic                  reg_req_i, reg_we_i;
   logic [9:0]            reg_addr_i;
   logic [7:0]            reg_wdata_i;
   logic                  reg_rvalid_o, reg_err_o, locked_o;
   logic [7:0]            reg_rdata_o;
   logic [NPeriphOut-1:0] periph_out_i, periph_oe_i;
   logic [NPeriphIn-1:0]  periph_in_o;
   logic [NPads-1:0]      pad_in_i, pad_out_o, pad_oe_o;
   logic [2*NPads-1:0]    pad_attr_o;

   int vectors = 0;
   int miscompares = 0;
   logic       rsp_valid, rsp_err;
   logic [7:0] rsp_rdata;

   always #5 clk_i = ~clk_i;

   pad_mux #(
      .NPads(NPads), .NPeriphOut(NPeriphOut), .NPeriphIn(NPeriphIn), .FilterCycles(FilterCycles)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .reg_req_i(reg_req_i), .reg_we_i(reg_we_i), .reg_addr_i(reg_addr_i), .reg_wdata_i(reg_wdata_i),
      .reg_rvalid_o(reg_rvalid_o), .reg_rdata_o(reg_rdata_o), .reg_err_o(reg_err_o),
      .periph_out_i(periph_out_i), .periph_oe_i(periph_oe_i), .periph_in_o(periph_in_o),
      .pad_in_i(pad_in_i), .pad_out_o(pad_out_o), .pad_oe_o(pad_oe_o),
      .pad_attr_o(pad_attr_o), .locked_o(locked_o)
   );

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // One request; response fields are captured in the following cycle.
   task automatic reg_access(input logic we, input logic [1:0] region, input logic [7:0] idx,
                             input logic [7:0] wdata);
      reg_req_i   = 1'b1;
      reg_we_i    = we;
      reg_addr_i  = {region, idx};
      reg_wdata_i = wdata;
      tick();
      reg_req_i   = 1'b0;
      reg_we_i    = 1'b0;
      rsp_valid   = reg_rvalid_o;
      rsp_err     = reg_err_o;
      rsp_rdata   = reg_rdata_o;
      $display("access we=%0b region=%0d idx=%0d wdata=%02h -> rvalid=%0b err=%0b rdata=%02h",
               we, region, idx, wdata, rsp_valid, rsp_err, rsp_rdata);
   endtask

   task automatic check_rsp(input string tag, input logic err, input logic [7:0] rdata);
      check({tag, "_rvalid"}, 64'(rsp_valid), 64'd1);
      check({tag, "_err"}, 64'(rsp_err), 64'(err));
      check({tag, "_rdata"}, 64'(rsp_rdata), 64'(rdata));
   endtask

   initial begin
      rst_ni = 1'b0; reg_req_i = 1'b0; reg_we_i = 1'b0; reg_addr_i = '0; reg_wdata_i = '0;
      periph_out_i = '0; periph_oe_i = '0; pad_in_i = '0;
      repeat (3) tick();
      check("reset_rvalid", 64'(reg_rvalid_o), 64'd0);
      check("reset_locked", 64'(locked_o), 64'd0);
      rst_ni = 1'b1;
      tick();

      reg_access(1'b0, 2'd0, 8'd5, 8'h00);
      check_rsp("rd_outsel5", 1'b0, 8'h00);
      tick();
      check("rvalid_one_cycle", 64'(reg_rvalid_o), 64'd0);
      check("reset_pad_oe", 64'(pad_oe_o), 64'd0);
      check("reset_periph_in", 64'(periph_in_o), 64'd0);
      check("reset_attr", 64'(pad_attr_o[63:0]), 64'd0);

      // Output mux
      periph_out_i[6] = 1'b1; periph_oe_i[6] = 1'b1;
      reg_access(1'b1, 2'd0, 8'd3, 8'd7);
      check_rsp("wr_outsel3", 1'b0, 8'h00);
      check("pad_out3_sel7", 64'(pad_out_o), 64'h8);
      check("pad_oe3_sel7", 64'(pad_oe_o), 64'h8);
      reg_access(1'b1, 2'd0, 8'd4, 8'd7);
      check("shared_periph_oe", 64'(pad_oe_o), 64'h18);
      periph_oe_i[63] = 1'b1;
      reg_access(1'b1, 2'd0, 8'd5, 8'd64);
      check("sel64_oe", 64'(pad_oe_o), 64'h38);
      check("sel64_out", 64'(pad_out_o), 64'h18);
      reg_access(1'b1, 2'd0, 8'd3, 8'd200);
      check("sel200_oe", 64'(pad_oe_o), 64'h30);
      reg_access(1'b0, 2'd0, 8'd3, 8'h00);
      check_rsp("rd_outsel3", 1'b0, 8'd200);

      // Input mux, unfiltered latency
      reg_access(1'b1, 2'd1, 8'd2, 8'd10);
      pad_in_i[9] = 1'b1;
      tick();
      check("in_lat1", 64'(periph_in_o), 64'd0);
      tick();
      check("in_lat2", 64'(periph_in_o), 64'h4);
      reg_access(1'b1, 2'd1, 8'd3, 8'd59);
      reg_access(1'b1, 2'd1, 8'd4, 8'd60);
      pad_in_i[58] = 1'b1;
      tick(); tick();
      check("insel_last_pad", 64'(periph_in_o), 64'hC);

      // Attribute and filter
      reg_access(1'b1, 2'd2, 8'd9, 8'h02);
      reg_access(1'b0, 2'd2, 8'd9, 8'h00);
      check_rsp("rd_attr9", 1'b0, 8'h02);
      check("pad_attr9", 64'(pad_attr_o[19:18]), 64'd2);
      pad_in_i[9] = 1'b0;
      repeat (8) tick();
      check("filt_settle_low", 64'(periph_in_o[2]), 64'd0);
      pad_in_i[9] = 1'b1;
      for (int j = 1; j <= 8; j++) begin
         if (j == 4) pad_in_i[9] = 1'b0;
         tick();
         check($sformatf("pulse_j%0d", j), 64'(periph_in_o[2]),
               64'((!FiltOn && j >= 2 && j <= 4) ? 1 : 0));
      end
      pad_in_i[9] = 1'b1;
      for (int j = 1; j <= 8; j++) begin
         tick();
         check($sformatf("level_j%0d", j), 64'(periph_in_o[2]),
               64'((FiltOn ? (j >= 6) : (j >= 2)) ? 1 : 0));
      end

      // Invalid indices
      reg_access(1'b1, 2'd1, 8'd48, 8'd5);
      check_rsp("wr_insel48", 1'b1, 8'h00);
      reg_access(1'b0, 2'd3, 8'd4, 8'h00);
      check_rsp("rd_ctrl4", 1'b1, 8'h00);
      reg_access(1'b0, 2'd0, 8'd59, 8'h00);
      check_rsp("rd_outsel59", 1'b1, 8'h00);
      reg_access(1'b0, 2'd1, 8'd47, 8'h00);
      check_rsp("rd_insel47", 1'b0, 8'h00);

      // Lock
      reg_access(1'b1, 2'd3, 8'd0, 8'h00);
      check_rsp("wr_ctrl0", 1'b0, 8'h00);
      check("unlocked", 64'(locked_o), 64'd0);
      reg_access(1'b1, 2'd3, 8'd0, 8'h01);
      check_rsp("wr_ctrl1", 1'b0, 8'h00);
      check("locked", 64'(locked_o), 64'd1);
      reg_access(1'b1, 2'd0, 8'd0, 8'd1);
      check_rsp("wr_locked", 1'b1, 8'h00);
      reg_access(1'b0, 2'd0, 8'd0, 8'h00);
      check_rsp("rd_outsel0_locked", 1'b0, 8'h00);
      reg_access(1'b1, 2'd3, 8'd0, 8'h00);
      check_rsp("wr_ctrl_locked", 1'b1, 8'h00);
      reg_access(1'b0, 2'd3, 8'd0, 8'h00);
      check_rsp("rd_ctrl", 1'b0, 8'h01);

      // Reset with a request in flight
      reg_req_i = 1'b1; reg_addr_i = {2'd3, 8'd0};
      #2 rst_ni = 1'b0;
      tick();
      reg_req_i = 1'b0;
      check("rst_mid_rvalid", 64'(reg_rvalid_o), 64'd0);
      check("rst_lock_clear", 64'(locked_o), 64'd0);
      check("rst_pad_oe", 64'(pad_oe_o), 64'd0);
      rst_ni = 1'b1;
      tick();
      reg_access(1'b0, 2'd0, 8'd3, 8'h00);
      check_rsp("rd_outsel3_after_rst", 1'b0, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
